// File: rtl/vliw_pkg.sv
// Shared types and constants for the VLIW fetch stage.
// Holds PC-select codes, fetch FSM states and bundle slice offsets.
package vliw_pkg;

    // Redirect select codes driven by the decoders; 2'b11 falls back to pc+1.
    localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
    localparam logic [1:0] PC_SEL_BR   = 2'b01;
    localparam logic [1:0] PC_SEL_JALR = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10,
        DROP  = 2'b11
    } fetch_state_e;

    // Slot positions inside the 48-bit bundle.
    localparam int SLOT32_MSB = 47;
    localparam int SLOT32_LSB = 16;
    localparam int SLOT16_MSB = 15;
    localparam int SLOT16_LSB = 0;

    // Field positions inside the 32-bit slot.
    localparam int OPC_MSB = 6;
    localparam int OPC_LSB = 0;
    localparam int F3_MSB  = 14;
    localparam int F3_LSB  = 12;

    // Field positions inside the 16-bit compressed slot.
    localparam int OPC_C_MSB = 1;
    localparam int OPC_C_LSB = 0;
    localparam int F3C_MSB   = 15;
    localparam int F3C_LSB   = 13;

    typedef struct packed {
        logic [31:0] slot32;
        logic [15:0] slot16;
    } bundle_t;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selector: pc+1, compressed-branch target or JALR target.
// Ports: pc_in select, fetch_pc, two targets in; seq_pc and next_pc out.
module fetch_next_pc
    import vliw_pkg::*;
#(
    parameter int PC_W = 16
) (
    input  logic [1:0]      pc_in,
    input  logic [PC_W-1:0] fetch_pc,
    input  logic [PC_W-1:0] branch_target,
    input  logic [PC_W-1:0] jalr_target,
    output logic [PC_W-1:0] seq_pc,
    output logic [PC_W-1:0] next_pc
);

    // Wraps naturally modulo 2^PC_W.
    assign seq_pc = fetch_pc + {{(PC_W-1){1'b0}}, 1'b1};

    always_comb begin
        next_pc = seq_pc;
        unique case (1'b1)
            (pc_in == PC_SEL_SEQ):  next_pc = seq_pc;
            (pc_in == PC_SEL_BR):   next_pc = branch_target;
            (pc_in == PC_SEL_JALR): next_pc = jalr_target;
            default:                next_pc = seq_pc;
        endcase
    end

endmodule

// File: rtl/vliw_fetch_stage.sv
// VLIW instruction-fetch stage with IF/ID register and one-entry holding buffer.
// Ports: clk/rst_n; imem req/addr/ack/rdata; id_stall, if_flush, pc_in,
// branch/jalr targets in; IF/ID valid/pc/slots and pre-sliced fields out.
module vliw_fetch_stage
    import vliw_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              BUNDLE_W = 48
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic                imem_ack,
    input  logic [BUNDLE_W-1:0] imem_rdata,
    input  logic                id_stall,
    input  logic                if_flush,
    input  logic [1:0]          pc_in,
    input  logic [PC_W-1:0]     branch_target,
    input  logic [PC_W-1:0]     jalr_target,
    output logic                if_id_valid,
    output logic [PC_W-1:0]     if_id_pc,
    output logic [31:0]         if_id_instr32,
    output logic [15:0]         if_id_instr16,
    output logic [6:0]          opcode,
    output logic [2:0]          funct_3,
    output logic [1:0]          opcode_c,
    output logic [2:0]          funct_3c
);

    fetch_state_e    state, state_n;
    logic [PC_W-1:0] fetch_pc, fetch_pc_n;
    logic [PC_W-1:0] addr_q, addr_n;
    logic            req_q, req_n;

    logic            v_q, v_n;
    logic [PC_W-1:0] pc_q, pc_n;
    bundle_t         ir_q, ir_n;

    logic            buf_v, buf_v_n;
    logic [PC_W-1:0] buf_pc, buf_pc_n;
    bundle_t         buf_q, buf_n;

    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] next_pc;
    bundle_t         rdata_b;
    logic            accept;

    fetch_next_pc #(
        .PC_W(PC_W)
    ) u_next_pc (
        .pc_in        (pc_in),
        .fetch_pc     (fetch_pc),
        .branch_target(branch_target),
        .jalr_target  (jalr_target),
        .seq_pc       (seq_pc),
        .next_pc      (next_pc)
    );

    assign rdata_b.slot32 = imem_rdata[SLOT32_MSB:SLOT32_LSB];
    assign rdata_b.slot16 = imem_rdata[SLOT16_MSB:SLOT16_LSB];

    // A bubble in IF/ID can always be overwritten, even under stall.
    assign accept = !v_q || !id_stall;

    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        addr_n     = addr_q;
        // ID consumes the current bundle whenever it accepts; refilled below.
        v_n        = accept ? 1'b0 : v_q;
        pc_n       = pc_q;
        ir_n       = ir_q;
        buf_v_n    = buf_v;
        buf_pc_n   = buf_pc;
        buf_n      = buf_q;

        if (if_flush) begin
            v_n        = 1'b0;
            buf_v_n    = 1'b0;
            fetch_pc_n = next_pc;
            unique case (state)
                FETCH: begin
                    if (imem_ack) begin
                        state_n = FETCH;
                        addr_n  = next_pc;
                    end else begin
                        // Outstanding request must finish on the old address.
                        state_n = DROP;
                    end
                end
                DROP: begin
                    state_n = DROP;
                end
                IDLE, HOLD: begin
                    state_n = FETCH;
                    addr_n  = next_pc;
                end
            endcase
        end else begin
            unique case (state)
                IDLE: begin
                    state_n = FETCH;
                    addr_n  = fetch_pc;
                end
                FETCH: begin
                    if (imem_ack) begin
                        fetch_pc_n = seq_pc;
                        if (accept) begin
                            v_n    = 1'b1;
                            pc_n   = fetch_pc;
                            ir_n   = rdata_b;
                            addr_n = seq_pc;
                        end else begin
                            buf_v_n  = 1'b1;
                            buf_pc_n = fetch_pc;
                            buf_n    = rdata_b;
                            state_n  = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (accept && buf_v) begin
                        v_n     = 1'b1;
                        pc_n    = buf_pc;
                        ir_n    = buf_q;
                        buf_v_n = 1'b0;
                        state_n = FETCH;
                        addr_n  = fetch_pc;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        state_n = FETCH;
                        addr_n  = fetch_pc;
                    end
                end
            endcase
        end

        req_n = (state_n == FETCH) || (state_n == DROP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            addr_q   <= RESET_PC;
            req_q    <= 1'b0;
            v_q      <= 1'b0;
            pc_q     <= '0;
            ir_q     <= '0;
            buf_v    <= 1'b0;
            buf_pc   <= '0;
            buf_q    <= '0;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            addr_q   <= addr_n;
            req_q    <= req_n;
            v_q      <= v_n;
            pc_q     <= pc_n;
            ir_q     <= ir_n;
            buf_v    <= buf_v_n;
            buf_pc   <= buf_pc_n;
            buf_q    <= buf_n;
        end
    end

    assign imem_req      = req_q;
    assign imem_addr     = addr_q;
    assign if_id_valid   = v_q;
    assign if_id_pc      = pc_q;
    assign if_id_instr32 = ir_q.slot32;
    assign if_id_instr16 = ir_q.slot16;

    assign opcode   = ir_q.slot32[OPC_MSB:OPC_LSB];
    assign funct_3  = ir_q.slot32[F3_MSB:F3_LSB];
    assign opcode_c = ir_q.slot16[OPC_C_MSB:OPC_C_LSB];
    assign funct_3c = ir_q.slot16[F3C_MSB:F3C_LSB];

endmodule

// File: tb/tb_vliw_fetch_stage.sv
// Directed testbench for vliw_fetch_stage.
// Memory returns {tag, addr, 16'hA5A5} so each bundle names its own address.
module tb_vliw_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [47:0] imem_rdata;
    logic        id_stall;
    logic        if_flush;
    logic [1:0]  pc_in;
    logic [15:0] branch_target;
    logic [15:0] jalr_target;
    logic        if_id_valid;
    logic [15:0] if_id_pc;
    logic [31:0] if_id_instr32;
    logic [15:0] if_id_instr16;
    logic [6:0]  opcode;
    logic [2:0]  funct_3;
    logic [1:0]  opcode_c;
    logic [2:0]  funct_3c;

    logic [15:0] tag;
    int          n_tests;
    int          n_fail;

    vliw_fetch_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .id_stall     (id_stall),
        .if_flush     (if_flush),
        .pc_in        (pc_in),
        .branch_target(branch_target),
        .jalr_target  (jalr_target),
        .if_id_valid  (if_id_valid),
        .if_id_pc     (if_id_pc),
        .if_id_instr32(if_id_instr32),
        .if_id_instr16(if_id_instr16),
        .opcode       (opcode),
        .funct_3      (funct_3),
        .opcode_c     (opcode_c),
        .funct_3c     (funct_3c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb imem_rdata = {tag, imem_addr, 16'hA5A5};

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        tag           = 16'h0000;
        rst_n         = 1'b0;
        imem_ack      = 1'b0;
        id_stall      = 1'b0;
        if_flush      = 1'b0;
        pc_in         = 2'b00;
        branch_target = 16'h0000;
        jalr_target   = 16'h0000;

        step();
        step();
        check("rst_req", imem_req, 0);
        check("rst_valid", if_id_valid, 0);
        check("rst_pc", if_id_pc, 0);
        check("rst_i32", if_id_instr32, 0);
        check("rst_i16", if_id_instr16, 0);
        check("rst_fields", {opcode, funct_3, opcode_c, funct_3c}, 0);

        // IDLE -> FETCH at RESET_PC
        rst_n = 1'b1;
        step();
        check("first_req", imem_req, 1);
        check("first_addr", imem_addr, 16'h0000);

        // Back-to-back acks: one bundle per cycle
        imem_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("seq_valid", if_id_valid, 1);
            check("seq_pc", if_id_pc, 16'(k));
            check("seq_addr", imem_addr, 16'(k + 1));
            check("seq_opcode", opcode, 7'(k));
            check("seq_i16", if_id_instr16, 16'hA5A5);
        end

        // IF/ID holds pc=2, ack of pc=3 under stall goes to HOLD
        id_stall = 1'b1;
        step();
        check("hold_req", imem_req, 0);
        check("hold_keep_pc", if_id_pc, 16'h0002);
        check("hold_keep_v", if_id_valid, 1);
        step();
        check("hold2_pc", if_id_pc, 16'h0002);
        check("hold2_req", imem_req, 0);
        id_stall = 1'b0;
        step();
        check("unhold_pc", if_id_pc, 16'h0003);
        check("unhold_i32", if_id_instr32, 32'h0000_0003);
        check("resume_addr", imem_addr, 16'h0004);
        check("resume_req", imem_req, 1);
        step();
        check("after_hold_pc", if_id_pc, 16'h0004);

        // Branch flush together with ack: acked bundle discarded
        if_flush      = 1'b1;
        pc_in         = 2'b01;
        branch_target = 16'h0040;
        step();
        check("brf_valid", if_id_valid, 0);
        check("brf_addr", imem_addr, 16'h0040);
        check("brf_req", imem_req, 1);
        if_flush = 1'b0;
        imem_ack = 1'b0;
        step();
        check("brf_wait_valid", if_id_valid, 0);
        check("brf_wait_addr", imem_addr, 16'h0040);
        imem_ack = 1'b1;
        step();
        check("brt_pc", if_id_pc, 16'h0040);
        check("brt_opcode", opcode, 7'h40);

        // JALR flush with outstanding request: DROP on stale address
        imem_ack    = 1'b0;
        if_flush    = 1'b1;
        pc_in       = 2'b10;
        jalr_target = 16'h0007;
        step();
        check("drop_addr", imem_addr, 16'h0041);
        check("drop_req", imem_req, 1);
        check("drop_valid", if_id_valid, 0);
        if_flush = 1'b0;
        tag      = 16'hDEAD;
        step();
        check("drop_addr2", imem_addr, 16'h0041);
        step();
        check("drop_addr3", imem_addr, 16'h0041);
        imem_ack = 1'b1;
        step();
        check("drop_done_addr", imem_addr, 16'h0007);
        check("drop_done_valid", if_id_valid, 0);
        tag = 16'h0000;
        step();
        check("jalr_pc", if_id_pc, 16'h0007);
        check("jalr_i32", if_id_instr32, 32'h0000_0007);
        check("jalr_valid", if_id_valid, 1);

        // PC wrap at all-ones, plus field slicing
        if_flush      = 1'b1;
        pc_in         = 2'b01;
        branch_target = 16'hFFFF;
        step();
        check("wrap_addr0", imem_addr, 16'hFFFF);
        if_flush = 1'b0;
        step();
        check("wrap_addr", imem_addr, 16'h0000);
        check("wrap_pc", if_id_pc, 16'hFFFF);
        check("wrap_opcode", opcode, 7'h7F);
        check("wrap_f3", funct_3, 3'h7);
        check("wrap_f3c", funct_3c, 3'h5);
        check("wrap_opc_c", opcode_c, 2'h1);
        step();
        check("wrap_next_pc", if_id_pc, 16'h0000);

        // Reset with an outstanding request
        imem_ack = 1'b0;
        id_stall = 1'b1;
        step();
        check("pre_rst_valid", if_id_valid, 1);
        check("pre_rst_req", imem_req, 1);
        rst_n = 1'b0;
        step();
        check("mid_rst_req", imem_req, 0);
        check("mid_rst_valid", if_id_valid, 0);
        rst_n    = 1'b1;
        id_stall = 1'b0;
        step();
        check("restart_addr", imem_addr, 16'h0000);
        check("restart_req", imem_req, 1);
        imem_ack = 1'b1;
        step();
        check("restart_pc", if_id_pc, 16'h0000);
        check("restart_valid", if_id_valid, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vliw_fetch_stage.md
Name: vliw_fetch_stage

Overview:
- Instruction-fetch stage with IF/ID register, directly upstream of the control circuits.
- Holds the bundle PC and fetches one 48-bit VLIW bundle per request from instruction memory: [47:16] is the 32-bit slot and [15:0] is the compressed slot.
- Presents the registered bundle and pre-sliced opcode/funct_3 fields to both decoders.
- Consumes the decoders' pc_in and IF_Flush to redirect the PC and squash the wrong-path bundle.

Parameters:
- PC_W, 16, bundle-index PC width; the PC counts bundles, not bytes.
- RESET_PC, 0, first bundle fetched after reset.
- BUNDLE_W, 48, bundle width; fixed at 32+16 and not meant to be overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- imem_req  out  1  fetch request; held high until imem_ack.
- imem_addr  out  PC_W  bundle address; stable while imem_req=1 and ack not yet seen.
- imem_ack  in  1  sampled at the edge; when 1, imem_rdata is valid this cycle.
- imem_rdata  in  BUNDLE_W  fetched bundle.
- id_stall  in  1  ID cannot accept; IF/ID holds its contents.
- if_flush  in  1  redirect (IF_Flush OR of both decoders).
- pc_in  in  2  redirect select: 00 = pc+1, 01 = branch_target, 10 = jalr_target, 11 = pc+1.
- branch_target  in  PC_W  compressed-branch target.
- jalr_target  in  PC_W  JALR target.
- if_id_valid  out  1  IF/ID holds a real bundle.
- if_id_pc  out  PC_W  PC of the IF/ID bundle.
- if_id_instr32  out  32  bundle[47:16].
- if_id_instr16  out  16  bundle[15:0].
- opcode  out  7  if_id_instr32[6:0].
- funct_3  out  3  if_id_instr32[14:12].
- opcode_c  out  2  if_id_instr16[1:0].
- funct_3c  out  3  if_id_instr16[15:13].

Behaviour:
- Reset: when rst_n=0 at an edge, the following are cleared:
  - fetch_pc=RESET_PC, state=IDLE, imem_req=0.
  - if_id_valid=0, if_id_pc=0, if_id_instr32=0, if_id_instr16=0, and so all sliced fields are 0.
  - Holding buffer cleared to invalid.
- Reset mid-request abandons the request; memory must tolerate the dropped req.
- Sliced fields are pure wires from the IF/ID registers; they are valid only when if_id_valid=1.
- "accept" means (!if_id_valid || !id_stall).
- FSM states:
  - IDLE: imem_req=0; go to FETCH next cycle.
  - FETCH: imem_req=1, imem_addr=fetch_pc.
    - On ack with accept: IF/ID <= {rdata, fetch_pc}, valid=1, fetch_pc <= fetch_pc+1, stay in FETCH.
    - On ack without accept: holding buffer <= {rdata, fetch_pc}, fetch_pc+1, go to HOLD.
    - Without ack: hold the address.
    - Sustained throughput is 1 bundle/cycle when ack=1 every cycle.
  - HOLD: imem_req=0. When accept, IF/ID <= buffer, valid=1, go to FETCH.
  - DROP: imem_req=1 with the stale imem_addr (the handshake must complete). On ack, discard rdata and go to FETCH. The new fetch_pc is already loaded.
- Flush (if_flush=1 at an edge) has priority over stall and over the FETCH/HOLD actions:
  - Next fetch_pc = target selected by pc_in.
  - if_id_valid <= 0 and the holding buffer is invalidated.
  - From FETCH with ack=0: go to DROP.
  - From FETCH with ack=1: rdata is discarded; go to FETCH.
  - From HOLD or IDLE: go to FETCH.
  - From DROP: stay in DROP; target updated.
- A flush does not write the target bundle in the same cycle. First valid target bundle appears ≥1 cycle after the ack of the new request.
- id_stall with if_id_valid=0 is ignored (bubble is overwritten).
- fetch_pc+1 wraps modulo 2^PC_W (all-ones -> 0).
- No output is X after reset; rdata is never registered without ack.

Decomposition:
- Shared package vliw_pkg:
  - PC_SEL_SEQ=2'b00, PC_SEL_BR=2'b01, PC_SEL_JALR=2'b10.
  - Fetch-state enum {IDLE, FETCH, HOLD, DROP}.
  - Bundle field slice offsets (32-slot [47:16], 16-slot [15:0], opcode/funct3 positions).
- One sub-module, fetch_next_pc: a combinational mux of pc_in/targets/pc+1. The FSM, buffer and IF/ID register stay in the top module.

Test Plan:
- Reset then ack=1 every cycle, rdata = {addr, 16'hA5A5} -> addr 0,1,2,3 on consecutive cycles; if_id_pc follows one cycle later; opcode = rdata[22:16].
- Stall with IF/ID valid at pc=2 while req pc=3 acks -> HOLD; pc=3 bundle appears the cycle after id_stall drops, then fetching resumes at 4; nothing lost or duplicated.
- if_flush, pc_in=01, branch_target=0x40, ack=1 in the same cycle -> if_id_valid=0 next cycle, next imem_addr=0x40, the acked bundle is never presented.
- if_flush, pc_in=10, jalr_target=0x7, ack delayed 3 cycles -> DROP holds the old addr until ack, then requests 0x7; the stale data is discarded.
- fetch_pc=0xFFFF, PC_W=16, sequential ack -> next addr 0x0000.
- rst_n=0 during an outstanding request -> next cycle imem_req=0, if_id_valid=0; fetch restarts at RESET_PC.
